seq_detector_mealy_1011: RTL and testbench
==========================================

// Module: seq_detector_mealy_1011
// PURPOSE
//   Serial bit-pattern detector, Mealy style. Samples one bit of din per clk rising edge.
//   'detected' is combinational: it goes high in the same cycle as the final pattern bit.
//   It sits after a bit-serial front end and flags each occurrence of a fixed pattern.
//   Default pattern is 1011 (MSB received first), with overlapping matches allowed.
// PARAMETERS
//   SEQ_LEN  4        pattern length in bits; legal range 2..16
//   SEQ      4'b1011  pattern; bit SEQ_LEN-1 is received first
//   OVERLAP  1        1: a pattern suffix may start the next match; 0: restart from empty after a hit
// PORTS
//   clk       input   1  system clock; all state updates on rising edge
//   reset     input   1  synchronous, active-high reset
//   din       input   1  serial data bit; changes after the clk rising edge, stable before the next one
//   detected  output  1  high while the bits matched so far plus the current din complete SEQ
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-high. No asynchronous paths.
//   - State encoding: matched-prefix count, states S0..S(SEQ_LEN-1).
//     S0 means no bits matched; Sk means the last k bits received equal the top k bits of SEQ.
//     For the default pattern: S0=none, S1="1", S2="10", S3="101".
//   - Reset: on a clk rising edge with reset=1, state becomes S0.
//     While reset=1, detected=0 regardless of din.
//   - Transition, rising edge with reset=0, from state Sk with input din:
//     * din equals expected bit SEQ[SEQ_LEN-1-k] and k<SEQ_LEN-1: go to S(k+1).
//     * din completes the pattern (k=SEQ_LEN-1, din matches):
//       OVERLAP=1: go to S(j), where j = length of the longest proper suffix of SEQ that is also a prefix of SEQ.
//       OVERLAP=0: go to S0.
//     * mismatch: go to S(j), where j = length of the longest proper suffix of (matched prefix, din) that is a prefix of SEQ.
//       j may be 0.
//     * Compute the transition table at elaboration with a constant function (KMP failure function).
//       Do not hand-code it.
//   - Default table, 1011 (state / din=0 / din=1):
//     S0: S0 / S1      S1: S2 / S1      S2: S0 / S3      S3: S2 / S1 (plus detect)
//   - Output: detected = !reset && (state==S(SEQ_LEN-1)) && (din==SEQ[0]).
//     It is purely combinational from state and din, with zero latency.
//     It may glitch while din settles; consumers must sample it on clk.
//   - Consecutive hits are allowed. Each hit is a one-cycle pulse unless the next bits complete another match.
//   - Reset asserted mid-sequence: the partial match is discarded; after reset the full pattern is needed again.
//   - din X/Z handling is out of scope; no registered output, no enable.
// TESTING
//   1. Hold reset=1 for 2 cycles with din=1 -> detected=0 throughout; state=S0 after release.
//   2. din=1,0,1,1 -> detected=1 only in the cycle din=1 (4th bit) is applied; 0 on bits 1-3.
//   3. Stream 1,0,1,1,0,1,0,1,1,0,0,1,0 -> detected high exactly on bits 4 and 9.
//      Tail 0,0,1,0 gives no hit.
//   4. OVERLAP=1, stream 1,0,1,1,0,1,1 -> hits on bits 4 and 7.
//      OVERLAP=0, same stream -> hit on bit 4 only.
//   5. din=1,0,1 then reset=1 for one cycle, then din=1 -> no hit.
//      Then 1,0,1,1 -> hit on the last bit.
//   6. Stream 1,1,1,0,1,1 -> hit on bit 6 only (checks the mismatch fallback S1 --1--> S1).
//      Also re-run with SEQ_LEN=3, SEQ=3'b110 on stream 1,1,1,0 -> hit on bit 4.

Source files
------------

// File: rtl/seq_detector_mealy_1011.sv
// Serial Mealy pattern detector. It matches a fixed bit pattern, MSB first,
// and can either allow or forbid overlapping matches. The state is the length
// of the matched prefix. The next-state table is built when the design is
// elaborated, using a KMP-style constant function. The output 'detected' is
// combinational and goes high in the same cycle as the final pattern bit.
module seq_detector_mealy_1011 #(
  parameter int                 SEQ_LEN = 4,        // 2..16
  parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1011,  // bit SEQ_LEN-1 is received first
  parameter int                 OVERLAP = 1         // 1: suffix may start the next match
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic detected
);

  localparam int SW   = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
  localparam int NSTS = 2 ** SW;
  localparam logic [SW-1:0] LAST = SW'(SEQ_LEN - 1);

  // Returns the next matched-prefix length after state k sees bit b. This is
  // the longest suffix of (prefix_k, b) that is also a prefix of SEQ. A full
  // match is capped at SEQ_LEN-1, which gives the overlap restart point.
  // When overlap is disabled, a full match goes back to the empty state.
  function automatic int kmp_next(input int k, input int b);
    logic [15:0] pat;
    logic [15:0] sh;
    int          best;
    bit          ok;
    int          bit_a;
    int          bit_p;
    pat  = 16'(SEQ);
    best = 0;
    if (k == SEQ_LEN - 1 && b == int'(SEQ[0]) && OVERLAP == 0) return 0;
    for (int j = 1; j <= k + 1 && j < SEQ_LEN; j++) begin
      ok = 1'b1;
      // Age a = 0 is the incoming bit. Age a > 0 walks back through the prefix.
      for (int a = 0; a < j; a++) begin
        if (a == 0) begin
          bit_a = b;
        end else begin
          sh    = pat >> (SEQ_LEN - k + a - 1);
          bit_a = int'(sh[0]);
        end
        sh    = pat >> (SEQ_LEN - j + a);
        bit_p = int'(sh[0]);
        if (bit_a != bit_p) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  logic [SW-1:0] state;
  logic [SW-1:0] nxt_tbl [NSTS][2];

  // Constant transition table. Unreachable encodings fall back to the empty state.
  for (genvar k = 0; k < NSTS; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      if (k < SEQ_LEN) begin : g_live
        localparam logic [SW-1:0] NXT = SW'(kmp_next(k, b));
        assign nxt_tbl[k][b] = NXT;
      end else begin : g_dead
        assign nxt_tbl[k][b] = '0;
      end
    end
  end

  // State register: synchronous reset to the empty match, then one table lookup per bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, so the order of blocks does not matter.
    if (reset) begin
      state <= '0;
    end else begin
      state <= nxt_tbl[state][din];
    end
  end

  // Mealy output: the last prefix bit is already held, and din supplies the final bit.
  assign detected = !reset && (state == LAST) && (din == SEQ[0]);

endmodule

// File: tb/tb_seq_detector_mealy_1011.sv
// Directed bench for seq_detector_mealy_1011. It uses three instances: the
// default 1011 pattern with overlap, 1011 without overlap, and 110 with
// overlap. Each step records its expected output in a scoreboard queue.
// The bench pops and compares that entry on the following falling edge.
module tb_seq_detector_mealy_1011;

  logic clk = 1'b0;
  logic reset;
  logic din_a, din_b, din_c;
  logic det_a, det_b, det_c;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    sel;
    logic  exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_detector_mealy_1011 dut_a (
    .clk(clk), .reset(reset), .din(din_a), .detected(det_a)
  );

  seq_detector_mealy_1011 #(.SEQ_LEN(4), .SEQ(4'b1011), .OVERLAP(0)) dut_b (
    .clk(clk), .reset(reset), .din(din_b), .detected(det_b)
  );

  seq_detector_mealy_1011 #(.SEQ_LEN(3), .SEQ(3'b110), .OVERLAP(1)) dut_c (
    .clk(clk), .reset(reset), .din(din_c), .detected(det_c)
  );

  // Pop the oldest expectation and compare it with the selected instance's output.
  task automatic check_out();
    exp_t e;
    logic obs;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    case (e.sel)
      0:       obs = det_a;
      1:       obs = det_b;
      default: obs = det_c;
    endcase
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0b expected=%0b", e.tag, obs, e.exp);
    end
  endtask

  // Drive one bit just after the rising edge, then sample at the falling edge.
  task automatic step(input int sel, input logic d, input logic rst,
                      input string tag, input logic exp);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    din_a = 1'b0;
    din_b = 1'b0;
    din_c = 1'b0;
    case (sel)
      0:       din_a = d;
      1:       din_b = d;
      default: din_c = d;
    endcase
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
    @(negedge clk);
    check_out();
  endtask

  // Play n bits, first bit at position n-1. The hit mask is aligned with the bits.
  task automatic stream(input int sel, input string tag, input int n,
                        input logic [15:0] bits, input logic [15:0] hits);
    for (int i = 0; i < n; i++) begin
      step(sel, bits[4'(n - 1 - i)], 1'b0, $sformatf("%s_b%0d", tag, i + 1),
           hits[4'(n - 1 - i)]);
    end
  endtask

  // One reset cycle with din=1 on the selected instance. The output must stay low.
  task automatic do_reset(input int sel, input string tag);
    step(sel, 1'b1, 1'b1, tag, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    din_a = 1'b0;
    din_b = 1'b0;
    din_c = 1'b0;

    // Reset held for two cycles with din=1.
    step(0, 1'b1, 1'b1, "rst_hold_a1", 1'b0);
    step(0, 1'b1, 1'b1, "rst_hold_a2", 1'b0);
    step(1, 1'b1, 1'b1, "rst_hold_b", 1'b0);

    // Single pattern from the empty state.
    stream(0, "basic", 4, 16'b1011, 16'b0001);

    // Longer stream; hits on bits 4 and 9, no hit in the 0,0,1,0 tail.
    do_reset(0, "rst_t3");
    stream(0, "long", 13, 16'b1011010110010, 16'b0001000010000);

    // Overlap allowed versus forbidden.
    do_reset(0, "rst_t4a");
    stream(0, "ovl1", 7, 16'b1011011, 16'b0001001);
    do_reset(1, "rst_t4b");
    stream(1, "ovl0", 7, 16'b1011011, 16'b0001000);

    // Partial match, then reset while sitting in the last-prefix state with
    // din=1; reset must mask the output. The partial match must be gone afterwards.
    do_reset(0, "rst_t5pre");
    stream(0, "pre", 3, 16'b101, 16'b000);
    step(0, 1'b1, 1'b1, "rst_mid_mask", 1'b0);
    step(0, 1'b1, 1'b0, "post_rst_1", 1'b0);
    do_reset(0, "rst_t5b");
    stream(0, "after", 4, 16'b1011, 16'b0001);

    // Mismatch fallback S1 --1--> S1.
    do_reset(0, "rst_t6");
    stream(0, "fallback", 6, 16'b111011, 16'b000001);

    // Three-bit pattern 110.
    do_reset(2, "rst_t6b");
    stream(2, "seq110", 4, 16'b1110, 16'b0001);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
